// File: rtl/i2c_apb_sequencer_pkg.sv
// i2c_seq_pkg: shared definitions for the I2C-APB sequencer.
//   - register map of the I2C controller's APB slave
//   - STATUS bit positions and the START command value
//   - state encodings for the sequencer FSM and the APB transfer engine
package i2c_seq_pkg;

  localparam logic [6:0] REG_ADDR = 7'h00;  // {saddr, rw}
  localparam logic [6:0] REG_TX   = 7'h04;
  localparam logic [6:0] REG_RX   = 7'h08;
  localparam logic [6:0] REG_CMD  = 7'h0C;
  localparam logic [6:0] REG_STAT = 7'h10;

  localparam int STAT_BUSY = 0;
  localparam int STAT_NACK = 1;

  localparam logic [7:0] CMD_START = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_TX,
    S_WR_CMD,
    S_POLL,
    S_GAP,
    S_RD_RX,
    S_RESP
  } seq_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_ACCESS
  } xfer_state_t;

  // States that own exactly one APB transfer.
  function automatic logic is_xfer_state(input seq_state_t s);
    return s inside {S_WR_ADDR, S_WR_TX, S_WR_CMD, S_POLL, S_RD_RX};
  endfunction

endpackage

// File: rtl/i2c_apb_sequencer_if.sv
// i2c_apb_sequencer_if: APB bus between the sequencer (master) and the
// I2C controller register slave.
//   PSELx, PENABLE, PWRITE, PADDR[6:0], PWDATA[7:0] : master -> slave
//   PRDATA[7:0], PREADY                              : slave -> master
interface i2c_apb_sequencer_if;
  logic       PSELx;
  logic       PENABLE;
  logic       PWRITE;
  logic [6:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/i2c_apb_sequencer_apb_xfer.sv
// apb_xfer: single-transfer APB master handshake.
//   clk, rst          : clock, synchronous active-high reset
//   start             : launch one transfer (accepted only when idle)
//   addr/write/wdata  : transfer attributes, captured on start
//   busy              : a transfer is in SETUP or ACCESS
//   xfer_done         : ACCESS cycle in which PREADY = 1 (transfer completes)
//   rdata             : PRDATA, valid together with xfer_done
//   apb               : APB master modport
module apb_xfer
  import i2c_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       write,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       xfer_done,
  output logic [7:0] rdata,
  i2c_apb_sequencer_if.master apb
);

  xfer_state_t state, state_nx;
  logic [6:0]  addr_q;
  logic        write_q;
  logic [7:0]  wdata_q;

  always_ff @(posedge clk) begin
    if (rst) state <= X_IDLE;
    else     state <= state_nx;
  end

  // Bus attributes are cleared by reset so the bus idles at all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (start && state == X_IDLE) begin
      addr_q  <= addr;
      write_q <= write;
      wdata_q <= wdata;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      X_IDLE:   if (start) state_nx = X_SETUP;
      X_SETUP:  state_nx = X_ACCESS;
      X_ACCESS: if (apb.PREADY) state_nx = X_IDLE;
      default:  state_nx = X_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != X_IDLE);
    xfer_done = (state == X_ACCESS) && apb.PREADY;
    rdata     = apb.PRDATA;
  end

  assign apb.PSELx   = (state != X_IDLE);
  assign apb.PENABLE = (state == X_ACCESS);
  assign apb.PWRITE  = write_q;
  assign apb.PADDR   = addr_q;
  assign apb.PWDATA  = wdata_q;

endmodule

// File: rtl/i2c_apb_sequencer.sv
// i2c_apb_sequencer: round-robin arbiter + APB register sequencer that turns
// a single-byte I2C read/write request into the controller's register
// program (ADDR, TX, CMD, STAT polling, RX).
//   PCLK, PRESET       : clock, synchronous active-high reset
//   req[1:0]           : request levels, held until done
//   req_rw[1:0]        : 1 = I2C read, 0 = I2C write
//   req_saddr[13:0]    : 7-bit slave address per requester
//   req_wdata[15:0]    : write byte per requester
//   gnt[1:0]           : one-hot pulse when a request is accepted
//   done[1:0]          : one-hot pulse when the transaction completes
//   err                : with done, NACK (or poll timeout)
//   rdata[7:0]         : last read byte, held until the next done
//   apb                : APB master modport to the I2C controller
// Build option: define I2C_SEQ_TIMEOUT_EN to bound STATUS polling to
// POLL_MAX reads (err = 1 on expiry).
module i2c_apb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 4
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [7*N_REQ-1:0]   req_saddr,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [7:0]           rdata,
  i2c_apb_sequencer_if.master  apb
);

  // A zero poll limit would time out before the first STATUS read.
  if (POLL_MAX < 1) begin : g_poll_max_invalid
  end

  seq_state_t  state, state_nx;
  logic        start_q;
  logic        rr_ptr;
  logic        winner;
  logic        win_nx;
  logic        err_q;
  logic [15:0] gap_cnt;
  logic        rw_q;
  logic [6:0]  saddr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;

  logic        x_start, x_busy, x_done, x_write;
  logic [6:0]  x_addr;
  logic [7:0]  x_wdata, x_rdata;

  logic        poll_busy, poll_nack, poll_timeout;
  logic        grant_now;

  // Current pointer wins if it is requesting, otherwise the other side.
  assign win_nx    = req[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign grant_now = (state == S_IDLE) && (|req);

  assign poll_busy = x_rdata[STAT_BUSY];
  assign poll_nack = x_rdata[STAT_NACK];

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [9:0] poll_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET)                            poll_cnt <= '0;
    else if (grant_now)                    poll_cnt <= '0;
    else if (state == S_POLL && x_done)    poll_cnt <= poll_cnt + 10'd1;
  end

  // poll_cnt counts completed polls before this one, hence the +1.
  assign poll_timeout = poll_busy && ((int'(poll_cnt) + 1) >= POLL_MAX);
`else
  assign poll_timeout = 1'b0;
`endif

  // State register; start_q launches one APB transfer on entry to a
  // transfer state (or on a POLL -> POLL re-entry when POLL_GAP = 0).
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= is_xfer_state(state_nx) && ((state_nx != state) || x_done);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rr_ptr  <= 1'b0;
      winner  <= 1'b0;
      err_q   <= 1'b0;
      gap_cnt <= '0;
    end else begin
      if (grant_now) begin
        winner <= win_nx;
        rr_ptr <= ~win_nx;
        err_q  <= 1'b0;
      end
      if (state == S_POLL && x_done)
        err_q <= (!poll_busy && poll_nack) || poll_timeout;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (grant_now) begin
      rw_q    <= req_rw[win_nx];
      saddr_q <= win_nx ? req_saddr[13:7] : req_saddr[6:0];
      wdata_q <= win_nx ? req_wdata[15:8] : req_wdata[7:0];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)                         rdata_q <= 8'h00;
    else if (state == S_RD_RX && x_done) rdata_q <= x_rdata;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (|req) state_nx = S_WR_ADDR;
      S_WR_ADDR: if (x_done) state_nx = rw_q ? S_WR_CMD : S_WR_TX;
      S_WR_TX:   if (x_done) state_nx = S_WR_CMD;
      S_WR_CMD:  if (x_done) state_nx = S_POLL;
      S_POLL: begin
        if (x_done) begin
          if (poll_busy) begin
            if (poll_timeout)       state_nx = S_RESP;
            else if (POLL_GAP == 0) state_nx = S_POLL;
            else                    state_nx = S_GAP;
          end else if (poll_nack) begin
            state_nx = S_RESP;
          end else begin
            state_nx = rw_q ? S_RD_RX : S_RESP;
          end
        end
      end
      S_GAP:     if (gap_cnt == 16'(POLL_GAP - 1)) state_nx = S_POLL;
      S_RD_RX:   if (x_done) state_nx = S_RESP;
      S_RESP:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    x_start = start_q && !x_busy;
    x_addr  = REG_ADDR;
    x_write = 1'b0;
    x_wdata = 8'h00;
    case (state)
      S_WR_ADDR: begin x_addr = REG_ADDR; x_write = 1'b1; x_wdata = {saddr_q, rw_q}; end
      S_WR_TX:   begin x_addr = REG_TX;   x_write = 1'b1; x_wdata = wdata_q;         end
      S_WR_CMD:  begin x_addr = REG_CMD;  x_write = 1'b1; x_wdata = CMD_START;       end
      S_POLL:    begin x_addr = REG_STAT; x_write = 1'b0;                            end
      S_RD_RX:   begin x_addr = REG_RX;   x_write = 1'b0;                            end
      default:   begin x_addr = REG_ADDR; x_write = 1'b0;                            end
    endcase

    gnt  = '0;
    done = '0;
    // gnt marks the first WR_ADDR cycle, i.e. the cycle after arbitration.
    if (state == S_WR_ADDR && start_q) gnt  = winner ? 2'b10 : 2'b01;
    if (state == S_RESP)               done = winner ? 2'b10 : 2'b01;
    err = (state == S_RESP) && err_q;
  end

  assign rdata = rdata_q;

  apb_xfer u_apb_xfer (
    .clk       (PCLK),
    .rst       (PRESET),
    .start     (x_start),
    .addr      (x_addr),
    .write     (x_write),
    .wdata     (x_wdata),
    .busy      (x_busy),
    .xfer_done (x_done),
    .rdata     (x_rdata),
    .apb       (apb)
  );

endmodule
